// File: rtl/perf_run_ctrl.sv
// perf_run_ctrl: benchmark run sequencer (start/stop window, timeout, run-length history); optional PERF_AUTO_REARM_EN; ports: CLK_50, resetN, pc, pc_valid, key_n, hist_sel in; state, cnt_en, cnt_clear, run_cycles, last_cycles, hist_cycles, hist_count, timeout out
module perf_run_ctrl #(
  parameter logic [15:0] START_PC     = 16'h0000,
  parameter logic [15:0] FINAL_PC     = 16'hFFFF,
  parameter logic [31:0] MAX_CYCLES   = 32'hFFFF_FFFF,
  parameter int          HIST_DEPTH   = 4,
  parameter bit          ARM_ON_RESET = 1'b1,
  parameter logic [31:0] REARM_DELAY  = 32'd50_000_000,
  localparam int         AW           = $clog2(HIST_DEPTH),
  localparam int         CW           = AW + 1
) (
  input  logic          CLK_50,
  input  logic          resetN,
  input  logic [15:0]   pc,
  input  logic          pc_valid,
  input  logic          key_n,
  input  logic [AW-1:0] hist_sel,
  output logic [2:0]    state,
  output logic          cnt_en,
  output logic          cnt_clear,
  output logic [31:0]   run_cycles,
  output logic [31:0]   last_cycles,
  output logic [31:0]   hist_cycles,
  output logic [CW-1:0] hist_count,
  output logic          timeout
);
  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, RUNNING = 3'd2, DONE = 3'd3, TIMEOUT = 3'd4} st_t;
  st_t st;
  logic k1, k2, k3;
  logic [31:0] hist [HIST_DEPTH];
  logic [AW-1:0] wptr;
`ifdef PERF_AUTO_REARM_EN
  logic [31:0] rd;
`endif
  logic key_press, start_hit, final_hit;
  assign key_press   = k3 & ~k2;
  assign start_hit   = pc_valid && pc == START_PC;
  assign final_hit   = pc_valid && pc == FINAL_PC;
  assign state       = st;
  assign hist_cycles = hist[wptr - hist_sel - AW'(1)];
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      st          <= ARM_ON_RESET ? ARMED : IDLE;
      k1          <= 1'b1;
      k2          <= 1'b1;
      k3          <= 1'b1;
      cnt_en      <= 1'b0;
      cnt_clear   <= 1'b0;
      run_cycles  <= '0;
      last_cycles <= '0;
      hist_count  <= '0;
      timeout     <= 1'b0;
      wptr        <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
`ifdef PERF_AUTO_REARM_EN
      rd          <= '0;
`endif
    end else begin
      k1        <= key_n;
      k2        <= k1;
      k3        <= k2;
      cnt_clear <= 1'b0;
      if (key_press) begin
        st         <= ARMED;
        timeout    <= 1'b0;
        run_cycles <= '0;
        cnt_en     <= 1'b0;
      end else begin
        case (st)
          ARMED: if (start_hit) begin
            st         <= RUNNING;
            run_cycles <= '0;
            cnt_clear  <= 1'b1;
            cnt_en     <= 1'b1;
          end
          RUNNING: if (final_hit) begin
            last_cycles <= run_cycles + 32'd1;
            hist[wptr]  <= run_cycles + 32'd1;
            wptr        <= wptr + AW'(1);
            if (hist_count != CW'(HIST_DEPTH)) hist_count <= hist_count + CW'(1);
            st          <= DONE;
            cnt_en      <= 1'b0;
`ifdef PERF_AUTO_REARM_EN
            rd          <= REARM_DELAY - 32'd1;
`endif
          end else if (run_cycles == MAX_CYCLES - 32'd1) begin
            last_cycles <= MAX_CYCLES;
            timeout     <= 1'b1;
            st          <= TIMEOUT;
            cnt_en      <= 1'b0;
          end else begin
            run_cycles <= run_cycles + 32'd1;
          end
`ifdef PERF_AUTO_REARM_EN
          DONE: if (rd == '0) begin
            st         <= ARMED;
            run_cycles <= '0;
          end else begin
            rd <= rd - 32'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_perf_run_ctrl.sv
// tb_perf_run_ctrl: directed self-checking bench for perf_run_ctrl
module tb_perf_run_ctrl;
  logic        CLK_50 = 1'b0;
  logic        resetN;
  logic [15:0] pc;
  logic        pc_valid;
  logic        key_n;
  logic [1:0]  hist_sel;
  logic [2:0]  state;
  logic        cnt_en, cnt_clear, timeout;
  logic [31:0] run_cycles, last_cycles, hist_cycles;
  logic [2:0]  hist_count;
  int passed = 0;
  int total = 0;

  perf_run_ctrl #(
    .START_PC(16'd10), .FINAL_PC(16'd20), .MAX_CYCLES(32'd8),
    .HIST_DEPTH(4), .ARM_ON_RESET(1'b1), .REARM_DELAY(32'd10)
  ) dut (
    .CLK_50(CLK_50), .resetN(resetN), .pc(pc), .pc_valid(pc_valid), .key_n(key_n),
    .hist_sel(hist_sel), .state(state), .cnt_en(cnt_en), .cnt_clear(cnt_clear),
    .run_cycles(run_cycles), .last_cycles(last_cycles), .hist_cycles(hist_cycles),
    .hist_count(hist_count), .timeout(timeout)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic press();
    key_n = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(3);
  endtask

  task automatic run(input int len);
    pc = 16'd10; pc_valid = 1'b1;
    tick(1);
    pc = 16'd0;
    tick(len - 1);
    pc = 16'd20;
    tick(1);
    pc_valid = 1'b0;
    chk("run_state", 32'(state), 32'd3);
    chk("run_last", last_cycles, 32'(len));
  endtask

  initial begin
    resetN = 1'b0; pc = 16'd0; pc_valid = 1'b0; key_n = 1'b1; hist_sel = 2'd0;
    #25;
    chk("rst_state", 32'(state), 32'd1);
    chk("rst_run", run_cycles, 32'd0);
    chk("rst_last", last_cycles, 32'd0);
    chk("rst_hcnt", 32'(hist_count), 32'd0);
    chk("rst_hist", hist_cycles, 32'd0);
    chk("rst_flags", {29'd0, cnt_en, cnt_clear, timeout}, 32'd0);
    resetN = 1'b1;
    tick(1);
    // basic run: start at edge k, final at edge k+5
    pc = 16'd10; pc_valid = 1'b1;
    tick(1);
    chk("k_state", 32'(state), 32'd2);
    chk("k_clear", 32'(cnt_clear), 32'd1);
    chk("k_en", 32'(cnt_en), 32'd1);
    chk("k_run", run_cycles, 32'd0);
    pc = 16'd0;
    tick(1);
    chk("k1_clear", 32'(cnt_clear), 32'd0);
    tick(3);
    chk("k4_run", run_cycles, 32'd4);
    chk("k4_clear", 32'(cnt_clear), 32'd0);
    pc = 16'd20;
    tick(1);
    pc_valid = 1'b0;
    chk("done_state", 32'(state), 32'd3);
    chk("done_last", last_cycles, 32'd5);
    chk("done_hist0", hist_cycles, 32'd5);
    chk("done_hcnt", 32'(hist_count), 32'd1);
    chk("done_en", 32'(cnt_en), 32'd0);
    // key press takes three edges after the falling edge
    key_n = 1'b0;
    tick(2);
    chk("key2_state", 32'(state), 32'd3);
    tick(1);
    chk("key3_state", 32'(state), 32'd1);
    chk("key3_run", run_cycles, 32'd0);
    chk("key3_last", last_cycles, 32'd5);
    key_n = 1'b1;
    tick(3);
    // final PC while armed, start PC without pc_valid
    pc = 16'd20; pc_valid = 1'b1;
    tick(1);
    chk("armfin_state", 32'(state), 32'd1);
    pc = 16'd10; pc_valid = 1'b0;
    tick(1);
    chk("novalid_state", 32'(state), 32'd1);
    chk("novalid_en", 32'(cnt_en), 32'd0);
    // timeout after MAX_CYCLES edges
    pc_valid = 1'b1;
    tick(1);
    pc = 16'd0;
    tick(7);
    chk("to7_state", 32'(state), 32'd2);
    chk("to7_run", run_cycles, 32'd7);
    tick(1);
    pc_valid = 1'b0;
    chk("to_state", 32'(state), 32'd4);
    chk("to_last", last_cycles, 32'd8);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_hcnt", 32'(hist_count), 32'd1);
    tick(5);
    chk("to_hold", 32'(state), 32'd4);
    press();
    chk("to_rearm", 32'(state), 32'd1);
    chk("to_clr", 32'(timeout), 32'd0);
    chk("to_keep_last", last_cycles, 32'd8);
    // abort mid-run with the key
    pc = 16'd10; pc_valid = 1'b1;
    tick(1);
    pc = 16'd0;
    tick(2);
    key_n = 1'b0;
    tick(2);
    chk("ab_running", 32'(state), 32'd2);
    tick(1);
    chk("ab_state", 32'(state), 32'd1);
    chk("ab_run", run_cycles, 32'd0);
    chk("ab_en", 32'(cnt_en), 32'd0);
    chk("ab_hcnt", 32'(hist_count), 32'd1);
    chk("ab_last", last_cycles, 32'd8);
    key_n = 1'b1;
    pc_valid = 1'b0;
    tick(3);
    // history wrap: five runs into a depth-4 buffer
    for (int l = 3; l <= 7; l++) begin
      run(l);
      press();
    end
    chk("h_cnt", 32'(hist_count), 32'd4);
    hist_sel = 2'd0; #1 chk("h_sel0", hist_cycles, 32'd7);
    hist_sel = 2'd1; #1 chk("h_sel1", hist_cycles, 32'd6);
    hist_sel = 2'd2; #1 chk("h_sel2", hist_cycles, 32'd5);
    hist_sel = 2'd3; #1 chk("h_sel3", hist_cycles, 32'd4);
    hist_sel = 2'd0;
    // DONE hold behaviour
    run(2);
    chk("h_wrap0", hist_cycles, 32'd2);
`ifdef PERF_AUTO_REARM_EN
    tick(9);
    chk("ar9_state", 32'(state), 32'd3);
    tick(1);
    chk("ar10_state", 32'(state), 32'd1);
    chk("ar10_run", run_cycles, 32'd0);
`else
    tick(1000);
    chk("hold_state", 32'(state), 32'd3);
    chk("hold_run", run_cycles, 32'd1);
`endif
    // asynchronous reset mid-run clears history
    press();
    pc = 16'd10; pc_valid = 1'b1;
    tick(1);
    pc = 16'd0;
    tick(2);
    #3 resetN = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd1);
    chk("ar_hcnt", 32'(hist_count), 32'd0);
    chk("ar_hist", hist_cycles, 32'd0);
    chk("ar_run", run_cycles, 32'd0);
    resetN = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/perf_run_ctrl.md
Name: perf_run_ctrl

Overview:
- Run sequencer for the CPU performance counter. Decides when a benchmark run starts, counts, stops and re-arms.
- A run starts on a start-PC match and stops on a final-PC match or on timeout.
- Cycle count of each completed run is captured into a small history buffer for the VGA/7-seg display path.
- Sits between the CPU core (pc) and the display logic. Replaces free-running count-from-reset with an explicit start/stop window.

Parameters:
- START_PC, 16'h0000, PC value that opens a run window.
- FINAL_PC, 16'hFFFF, PC value that closes a run window.
- MAX_CYCLES, 32'hFFFF_FFFF, run length at which the run is aborted as a timeout.
- HIST_DEPTH, 4, number of completed-run results retained (power of 2, 2..16).
- ARM_ON_RESET, 1, 1: leave reset in ARMED; 0: leave reset in IDLE.
- REARM_DELAY, 50_000_000, DONE-to-ARMED wait in cycles (optional feature only).

Ports:
- CLK_50  in  1  system clock, 50 MHz
- resetN  in  1  asynchronous, active-low reset
- pc  in  16  current CPU program counter
- pc_valid  in  1  pc is meaningful this cycle; PC matches are ignored when low
- key_n  in  1  asynchronous push button, active low; press = re-arm
- hist_sel  in  log2(HIST_DEPTH)  history read index; 0 = newest
- state  out  3  IDLE=0, ARMED=1, RUNNING=2, DONE=3, TIMEOUT=4
- cnt_en  out  1  high while RUNNING; gates the display counters
- cnt_clear  out  1  one-cycle pulse on every entry to RUNNING
- run_cycles  out  32  live cycle count of the current or most recent run
- last_cycles  out  32  result of the most recent completed run
- hist_cycles  out  32  history entry selected by hist_sel; 0 if never written
- hist_count  out  log2(HIST_DEPTH)+1  number of valid history entries, saturates at HIST_DEPTH
- timeout  out  1  sticky; set on entry to TIMEOUT

Behaviour:
- All outputs are registered except hist_cycles, which is a combinational read of the history registers.
- Reset values:
  - state = ARMED if ARM_ON_RESET, else IDLE.
  - All counts, history entries, hist_count, timeout, cnt_en and cnt_clear = 0.
- key_n handling: 2-FF synchronizer, then falling-edge detect giving a one-cycle key_press. No debounce; repeated presses simply re-arm.
- start_hit = pc_valid && pc==START_PC.
- final_hit = pc_valid && pc==FINAL_PC.
- State transitions, one edge each:
  - IDLE: key_press -> ARMED.
  - ARMED: start_hit -> RUNNING, run_cycles<=0, cnt_clear pulses on the same edge. start_hit wins over a simultaneous final_hit.
  - RUNNING, final_hit: last_cycles<=run_cycles+1, push to history, -> DONE.
  - RUNNING, else if run_cycles==MAX_CYCLES-1: last_cycles<=MAX_CYCLES, timeout<=1, no history push, -> TIMEOUT. final_hit on the same edge wins.
  - RUNNING, else: run_cycles<=run_cycles+1.
  - DONE / TIMEOUT: hold all counts. key_press -> ARMED.
- key_press in any state:
  - -> ARMED, timeout<=0, run_cycles<=0.
  - last_cycles and history are kept.
  - Overrides every other transition on that edge, including mid-run; an aborted run is not pushed.
- Run length = number of edges from the start_hit edge to the final_hit edge. Start on edge k, final on edge k+5 -> last_cycles=5.
- History:
  - Circular write pointer; a push writes the newest entry.
  - hist_sel=i returns the i-th newest entry.
  - hist_count increments per push and saturates at HIST_DEPTH. Once full, the oldest entry is overwritten.
  - Pushed value is visible on hist_cycles the cycle after the DONE edge.
- cnt_en = (state==RUNNING), registered alongside state.
- Arithmetic is 32-bit unsigned with no wrap: the MAX_CYCLES check prevents overflow.
- Asynchronous reset mid-run aborts immediately to the reset state. The history buffer is cleared.

Optional Feature:
- Macro: PERF_AUTO_REARM_EN.
- Defined:
  - DONE starts a REARM_DELAY-cycle down-counter; on expiry the block moves to ARMED and clears run_cycles.
  - key_press still re-arms immediately.
  - TIMEOUT never auto-rearms.
- Not defined: DONE holds until key_press or reset; no delay counter is synthesized.

Test Plan:
- Reset with ARM_ON_RESET=1, START_PC=10, FINAL_PC=20: pc=10 at edge k, pc=20 at edge k+5 -> state DONE, last_cycles=5, hist_cycles(sel 0)=5, hist_count=1, cnt_clear high only at edge k.
- pc=20 while ARMED, then pc=10 with pc_valid=0 -> state stays ARMED, cnt_en=0.
- MAX_CYCLES=8, start and no final -> TIMEOUT after 8 edges, last_cycles=8, timeout=1, hist_count unchanged; key press -> ARMED, timeout=0.
- Five runs of lengths 3,4,5,6,7 with HIST_DEPTH=4 -> hist_count=4; sel 0..3 return 7,6,5,4.
- key_n pulse during RUNNING -> ARMED 3 edges after the falling edge (sync + detect), run_cycles=0, no history push.
- PERF_AUTO_REARM_EN with REARM_DELAY=10: after DONE -> ARMED exactly 10 edges later. Without the macro -> DONE still held after 1000 edges.
